// File: rtl/memory_pkg.sv
// Shared types and sizing helpers for the synchronous scratch memory.
package memory_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 4;

    function automatic int addr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/memory_array.sv
// Single-port synchronous storage with a registered, load-enabled read port.
module memory_array #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic              re_i,
    input  logic              rzero_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Read register only moves on a completed read, so data is held between reads.
    always_ff @(posedge clk_i) begin
        if (rst_i || rzero_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/memory_sync_ctrl.sv
// Request/clear controller wrapped around memory_array: zero-fill sequencer,
// address range check, one-cycle read response and output-enable mask.
module memory_sync_ctrl
    import memory_pkg::*;
#(
    parameter  int DATA_W = DATA_W_DEF,
    parameter  int DEPTH  = DEPTH_DEF,
    localparam int ADDR_W = addr_w(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    input  logic              oe_i,
    output logic              rd_valid_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              err_o,
    output logic              busy_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_e            state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic              rd_valid_q;
    logic              err_q;

    logic              clearing;
    logic              accept;
    logic              in_range;
    logic              arr_we;
    logic              arr_re;
    logic              arr_rzero;
    logic [ADDR_W-1:0] arr_addr;
    logic [DATA_W-1:0] arr_wdata;
    logic [DATA_W-1:0] arr_rdata;

    assign clearing    = (state_q == ST_CLEAR);
    assign req_ready_o = !clearing && !clr_i;
    assign busy_o      = clearing;
    assign accept      = req_valid_i && req_ready_o;
    // Widen before comparing so non-power-of-two depths decode correctly.
    assign in_range    = 32'(req_addr_i) < 32'(DEPTH);

    always_comb begin
        arr_we    = !rst_i && (clearing || (accept && req_we_i && in_range));
        arr_addr  = clearing ? ptr_q : req_addr_i;
        arr_wdata = clearing ? '0 : req_wdata_i;
        arr_re    = accept && !req_we_i && in_range;
        arr_rzero = accept && !req_we_i && !in_range;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_CLEAR;
            ptr_q      <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            rd_valid_q <= accept && !req_we_i;
            err_q      <= accept && !in_range;
            case (state_q)
                ST_CLEAR: begin
                    if (ptr_q == LAST_ADDR) begin
                        state_q <= ST_READY;
                    end else begin
                        ptr_q <= ptr_q + ADDR_W'(1);
                    end
                end
                ST_READY: begin
                    if (clr_i) begin
                        state_q <= ST_CLEAR;
                        ptr_q   <= '0;
                    end
                end
                default: state_q <= ST_CLEAR;
            endcase
        end
    end

    memory_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (arr_we),
        .re_i    (arr_re),
        .rzero_i (arr_rzero),
        .addr_i  (arr_addr),
        .wdata_i (arr_wdata),
        .rdata_o (arr_rdata)
    );

    assign rd_valid_o = rd_valid_q;
    assign err_o      = err_q;
    assign rd_data_o  = oe_i ? arr_rdata : '0;

endmodule

// File: tb/tb_memory_sync_ctrl.sv
// Bench for memory_sync_ctrl: DEPTH=4 and DEPTH=5 instances share one stimulus
// stream and are checked against a cycle-level behavioural model.
module tb_memory_sync_ctrl;

    logic       clk = 1'b0;
    logic       rst, clr, req_valid, req_we, oe;
    logic [2:0] req_addr;
    logic [7:0] req_wdata;

    logic       g_ready [2];
    logic       g_busy  [2];
    logic       g_rv    [2];
    logic       g_err   [2];
    logic [7:0] g_rd    [2];

    int checks   = 0;
    int failures = 0;

    // Model state per instance (0: DEPTH=4, 1: DEPTH=5)
    int         depth [2] = '{4, 5};
    int         amask [2] = '{3, 7};
    bit         m_ready [2];
    int         m_cnt   [2];
    logic [7:0] m_mem   [2][8];
    logic [7:0] m_rd    [2];
    bit         m_rv    [2];
    bit         m_err   [2];

    always #5 clk = ~clk;

    memory_sync_ctrl #(.DATA_W(8), .DEPTH(4)) dut_a (
        .clk_i(clk), .rst_i(rst), .clr_i(clr), .req_valid_i(req_valid),
        .req_ready_o(g_ready[0]), .req_we_i(req_we), .req_addr_i(req_addr[1:0]),
        .req_wdata_i(req_wdata), .oe_i(oe), .rd_valid_o(g_rv[0]),
        .rd_data_o(g_rd[0]), .err_o(g_err[0]), .busy_o(g_busy[0])
    );

    memory_sync_ctrl #(.DATA_W(8), .DEPTH(5)) dut_b (
        .clk_i(clk), .rst_i(rst), .clr_i(clr), .req_valid_i(req_valid),
        .req_ready_o(g_ready[1]), .req_we_i(req_we), .req_addr_i(req_addr),
        .req_wdata_i(req_wdata), .oe_i(oe), .rd_valid_o(g_rv[1]),
        .rd_data_o(g_rd[1]), .err_o(g_err[1]), .busy_o(g_busy[1])
    );

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int a;
            bit acc;
            a   = int'(req_addr) & amask[k];
            acc = m_ready[k] && !clr && req_valid;
            if (rst) begin
                m_ready[k] = 0; m_cnt[k] = 0; m_rv[k] = 0; m_err[k] = 0; m_rd[k] = 8'h00;
            end else if (!m_ready[k]) begin
                m_mem[k][m_cnt[k]] = 8'h00;
                m_cnt[k]++;
                if (m_cnt[k] == depth[k]) m_ready[k] = 1;
                m_rv[k] = 0; m_err[k] = 0;
            end else begin
                m_rv[k]  = acc && !req_we;
                m_err[k] = acc && (a >= depth[k]);
                if (clr) begin
                    m_ready[k] = 0; m_cnt[k] = 0;
                end else if (acc && a < depth[k]) begin
                    if (req_we) m_mem[k][a] = req_wdata;
                    else        m_rd[k] = m_mem[k][a];
                end else if (acc && !req_we) begin
                    m_rd[k] = 8'h00;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input logic v, input logic we, input logic [2:0] ad, input logic [7:0] wd);
        req_valid = v; req_we = we; req_addr = ad; req_wdata = wd;
        tick();
    endtask

    task automatic test_reset();
        int first [2];
        rst = 1; clr = 0; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; oe = 1;
        tick(); tick();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({g_ready[k], g_busy[k], g_rv[k], g_err[k]} !== 4'b0100 || g_rd[k] !== 8'h00) begin
                failures++;
                $display("FAIL reset_values inst=%0d got rdy/busy/rv/err=%b%b%b%b rd=%h exp 0100 rd=00",
                         k, g_ready[k], g_busy[k], g_rv[k], g_err[k], g_rd[k]);
            end
        end
        rst = 0;
        first = '{-1, -1};
        for (int i = 1; i <= 12; i++) begin
            tick();
            for (int k = 0; k < 2; k++) if (first[k] < 0 && g_ready[k] === 1'b1) first[k] = i;
        end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (first[k] != depth[k]) begin
                failures++;
                $display("FAIL reset_clear_len inst=%0d ready_cycle=%0d exp=%0d", k, first[k], depth[k]);
            end
        end
    endtask

    task automatic test_zero_after_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 3'(i), 8'h00);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (g_rv[k] !== 1'b1 || g_rd[k] !== 8'h00) begin
                    failures++;
                    $display("FAIL zero_read inst=%0d addr=%0d rv=%b rd=%h exp rv=1 rd=00", k, i, g_rv[k], g_rd[k]);
                end
            end
        end
        drive(0, 0, 0, 0);
    endtask

    task automatic test_fill_readback();
        logic [7:0] pat [4] = '{8'h01, 8'h03, 8'h03, 8'h04};
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 3'(i), pat[i]);
            checks++;
            if (g_rv[0] !== 1'b0 || g_err[0] !== 1'b0) begin
                failures++;
                $display("FAIL write_no_rv addr=%0d rv=%b err=%b exp 0 0", i, g_rv[0], g_err[0]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 3'(i), 8'h00);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (g_rv[k] !== 1'b1 || g_rd[k] !== pat[i]) begin
                    failures++;
                    $display("FAIL b2b_read inst=%0d addr=%0d rv=%b rd=%h exp rv=1 rd=%h", k, i, g_rv[k], g_rd[k], pat[i]);
                end
            end
        end
        drive(0, 0, 0, 0);
        checks++;
        if (g_rv[0] !== 1'b0 || g_rd[0] !== 8'h04) begin
            failures++;
            $display("FAIL rd_hold rv=%b rd=%h exp rv=0 rd=04", g_rv[0], g_rd[0]);
        end
    endtask

    task automatic test_raw();
        drive(1, 1, 3'd2, 8'hA5);
        drive(1, 0, 3'd2, 8'h00);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (g_rv[k] !== 1'b1 || g_rd[k] !== 8'hA5) begin
                failures++;
                $display("FAIL raw_hazard inst=%0d rv=%b rd=%h exp rv=1 rd=a5", k, g_rv[k], g_rd[k]);
            end
        end
        drive(0, 0, 0, 0);
    endtask

    task automatic test_oe();
        oe = 0;
        drive(1, 0, 3'd3, 8'h00);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (g_rv[k] !== 1'b1 || g_rd[k] !== 8'h00) begin
                failures++;
                $display("FAIL oe_mask inst=%0d rv=%b rd=%h exp rv=1 rd=00", k, g_rv[k], g_rd[k]);
            end
        end
        req_valid = 0;
        oe = 1;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (g_rd[k] !== 8'h04) begin
                failures++;
                $display("FAIL oe_unmask inst=%0d rd=%h exp=04", k, g_rd[k]);
            end
        end
        tick();
        checks++;
        if (g_rv[1] !== 1'b0 || g_rd[1] !== 8'h04) begin
            failures++;
            $display("FAIL oe_hold rv=%b rd=%h exp rv=0 rd=04", g_rv[1], g_rd[1]);
        end
    endtask

    task automatic test_out_of_range();
        logic [7:0] exp_b [5] = '{8'h01, 8'h03, 8'hA5, 8'h04, 8'h00};
        drive(1, 1, 3'd6, 8'hFF);
        checks++;
        if (g_err[1] !== 1'b1 || g_rv[1] !== 1'b0 || g_err[0] !== 1'b0) begin
            failures++;
            $display("FAIL oor_write errB=%b rvB=%b errA=%b exp 1 0 0", g_err[1], g_rv[1], g_err[0]);
        end
        drive(1, 0, 3'd6, 8'h00);
        checks++;
        if (g_err[1] !== 1'b1 || g_rv[1] !== 1'b1 || g_rd[1] !== 8'h00) begin
            failures++;
            $display("FAIL oor_read errB=%b rvB=%b rdB=%h exp 1 1 00", g_err[1], g_rv[1], g_rd[1]);
        end
        checks++;
        if (g_rv[0] !== 1'b1 || g_rd[0] !== 8'hFF) begin
            failures++;
            $display("FAIL alias_read_a rv=%b rd=%h exp rv=1 rd=ff", g_rv[0], g_rd[0]);
        end
        drive(0, 0, 0, 0);
        checks++;
        if (g_err[1] !== 1'b0) begin
            failures++;
            $display("FAIL err_pulse errB=%b exp=0", g_err[1]);
        end
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 3'(i), 8'h00);
            checks++;
            if (g_rd[1] !== exp_b[i] || g_err[1] !== 1'b0 || g_rd[0] !== m_rd[0]) begin
                failures++;
                $display("FAIL oor_intact addr=%0d rdB=%h exp=%h errB=%b rdA=%h expA=%h",
                         i, g_rd[1], exp_b[i], g_err[1], g_rd[0], m_rd[0]);
            end
        end
        drive(0, 0, 0, 0);
    endtask

    task automatic test_clr_wins();
        int n [2];
        req_valid = 1; req_we = 1; req_addr = 3'd1; req_wdata = 8'h55; clr = 1;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (g_ready[k] !== 1'b0) begin
                failures++;
                $display("FAIL clr_blocks_ready inst=%0d ready=%b exp=0", k, g_ready[k]);
            end
        end
        tick();
        clr = 0; req_valid = 0;
        n = '{0, 0};
        for (int i = 0; i < 20; i++) begin
            for (int k = 0; k < 2; k++) if (g_busy[k] === 1'b1) n[k]++;
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (n[k] != depth[k]) begin
                failures++;
                $display("FAIL clr_busy_len inst=%0d busy_cycles=%0d exp=%0d", k, n[k], depth[k]);
            end
        end
        drive(1, 0, 3'd1, 8'h00);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (g_rv[k] !== 1'b1 || g_rd[k] !== 8'h00) begin
                failures++;
                $display("FAIL clr_zeroed inst=%0d rv=%b rd=%h exp rv=1 rd=00", k, g_rv[k], g_rd[k]);
            end
        end
        drive(0, 0, 0, 0);
    endtask

    task automatic test_reset_mid_clear();
        int first [2];
        clr = 1; tick(); clr = 0;
        tick(); tick();
        rst = 1; tick(); rst = 0;
        first = '{-1, -1};
        for (int i = 1; i <= 12; i++) begin
            tick();
            for (int k = 0; k < 2; k++) if (first[k] < 0 && g_ready[k] === 1'b1) first[k] = i;
        end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (first[k] != depth[k]) begin
                failures++;
                $display("FAIL mid_clear_reset inst=%0d ready_cycle=%0d exp=%0d", k, first[k], depth[k]);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            rst       = ($urandom_range(0, 99) == 0);
            clr       = ($urandom_range(0, 19) == 0);
            req_valid = ($urandom_range(0, 3) != 0);
            req_we    = $urandom_range(0, 1) != 0;
            req_addr  = 3'($urandom_range(0, 7));
            req_wdata = 8'($urandom);
            oe        = ($urandom_range(0, 7) != 0);
            tick();
            for (int k = 0; k < 2; k++) begin
                logic [7:0] exp_rd;
                exp_rd = oe ? m_rd[k] : 8'h00;
                checks++;
                if (g_ready[k] !== (m_ready[k] && !clr) || g_busy[k] !== !m_ready[k]) begin
                    failures++;
                    $display("FAIL rand_hs cyc=%0d inst=%0d ready=%b busy=%b exp %b %b",
                             c, k, g_ready[k], g_busy[k], m_ready[k] && !clr, !m_ready[k]);
                end
                checks++;
                if (g_rv[k] !== m_rv[k] || g_err[k] !== m_err[k]) begin
                    failures++;
                    $display("FAIL rand_pulse cyc=%0d inst=%0d rv=%b err=%b exp %b %b",
                             c, k, g_rv[k], g_err[k], m_rv[k], m_err[k]);
                end
                checks++;
                if (g_rd[k] !== exp_rd) begin
                    failures++;
                    $display("FAIL rand_data cyc=%0d inst=%0d rd=%h exp=%h", c, k, g_rd[k], exp_rd);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_after_reset();
        test_fill_readback();
        test_raw();
        test_oe();
        test_out_of_range();
        test_clr_wins();
        test_reset_mid_clear();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
